irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources; source 0 has highest priority.
REQ-002 Parameter HOLDOFF, default 2: guard cycles after ISR return before the next IRQ can be issued.
REQ-003 Port clk  input  1: the single clock; every register samples on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port src_req  input  NSRC: level interrupt lines from timer, UART and external sources.
REQ-006 Port mask_wr  input  1: one-cycle write strobe for the mask register.
REQ-007 Port mask_wdata  input  NSRC: new mask value; bit 1 means the source is enabled.
REQ-008 Port kernel  input  1: PC[31] of the ID-stage instruction; 1 means supervisor mode.
REQ-009 Port id_valid  input  1: the ID stage holds a real instruction, not a bubble.
REQ-010 Port id_stall  input  1: the ID stage is held this cycle (load-use or similar stall).
REQ-011 Port id_branch  input  1: the ID-stage instruction is a branch or jump.
REQ-012 Port eret  input  1: one-cycle pulse when the ISR return (jr $k0) leaves kernel mode.
REQ-013 Port IRQ  output  1: interrupt request to Control; drives PCSrc=3'b100.
REQ-014 Port irq_cause  output  log2(NSRC): index of the source taken, held until the next take.
REQ-015 Port pending  output  NSRC: pending interrupt flags.
REQ-016 Port mask  output  NSRC: current mask register.
REQ-017 Port in_isr  output  1: high from the IRQ cycle until ISR return.

Function
REQ-018 src_req SHALL be registered once; a rising edge is the current sample = 1 while the previous registered sample = 0.
REQ-019 A rising edge on an unmasked source SHALL set its pending bit on the next clock edge; edges on masked sources SHALL be ignored.
REQ-020 Clearing a mask bit SHALL NOT clear an existing pending bit; that bit SHALL simply not be eligible while masked.
REQ-021 A pending bit is eligible only when both the pending bit and the mask bit are 1.
REQ-022 A "safe slot" is id_valid=1, id_stall=0, id_branch=0 and kernel=0.
REQ-023 The FSM SHALL have these states: IDLE, ARM, TAKE, SERVICE, GUARD.
REQ-024 IDLE SHALL go to ARM when any pending bit is eligible.
REQ-025 ARM SHALL go to TAKE on the first safe-slot cycle.
REQ-026 ARM SHALL return to IDLE if no pending bit is eligible any longer (for example, it was masked).
REQ-027 In TAKE, IRQ SHALL be 1 for exactly one cycle.
REQ-028 In TAKE, irq_cause SHALL latch the lowest-index eligible source, and that source's pending bit SHALL clear.
REQ-029 TAKE SHALL go to SERVICE unconditionally.
REQ-030 IRQ SHALL be 0 in every state other than TAKE.
REQ-031 SERVICE SHALL ignore new pending bits and leave only on eret=1, going to GUARD.
REQ-032 GUARD SHALL count HOLDOFF cycles and then go to IDLE; eret is ignored outside SERVICE.
REQ-033 If the take-clear and a new edge hit the same pending bit in the same cycle, the set SHALL win.
REQ-034 A mask_wr in the TAKE cycle SHALL NOT change which source is taken in that cycle.
REQ-035 in_isr SHALL be 1 in TAKE and SERVICE, and 0 otherwise.

Reset
REQ-036 Asserting reset (low) SHALL, immediately and asynchronously, force:
- state to IDLE;
- pending, irq_cause, the edge-detect register and the GUARD counter to 0;
- mask to all ones;
- IRQ and in_isr to 0.
REQ-037 Reset asserted during SERVICE SHALL discard the in-progress ISR context without waiting for eret.
REQ-038 After reset deasserts, the first edge detection SHALL compare against the reset sample of 0, so a line already high at release counts as a rising edge.

Configuration
REQ-039 Macro IRQ_HOLDOFF_EN SHALL control the GUARD state.
- Defined: GUARD exists and delays IRQ by HOLDOFF cycles after eret.
- Undefined: SERVICE goes straight to IDLE on eret, and GUARD and its counter are not built.

Structure
REQ-040 A shared package mips_pkg SHALL hold:
- the FSM state enum;
- the PCSrc encodings (3'b100 = interrupt, 3'b101 = exception);
- the default values for NSRC and HOLDOFF.
REQ-041 Priority selection SHALL be a separate combinational sub-module, irq_prio_enc, that takes the eligible vector and returns a valid flag plus the lowest-set index.

Verification
REQ-042 Reset release with src_req=4'b0000, then a rising edge on src_req[2] -> pending=4'b0100 one cycle later; IRQ=1 for exactly one cycle at the first safe slot; irq_cause=2; pending=0.
REQ-043 Same-cycle edges on sources 1 and 3 -> the first take has cause 1; after eret plus 2 guard cycles, a second IRQ with cause 3.
REQ-044 Pending in ARM while kernel=1 for 10 cycles, then kernel=0 with id_stall=1 for 3 cycles -> IRQ stays 0 until the first cycle with kernel=0, id_stall=0, id_valid=1 and id_branch=0.
REQ-045 mask=4'b1110 and an edge on source 0 -> no pending bit, no IRQ; a later write of mask=4'b1111 with no new edge -> still no IRQ.
REQ-046 Reset pulsed low mid-SERVICE -> in_isr=0, IRQ=0, pending=0 and mask=4'b1111 asynchronously, before the next clock edge.
REQ-047 Build with and without IRQ_HOLDOFF_EN, source pending at eret -> the next IRQ comes no earlier than HOLDOFF+1 cycles after eret when enabled, and at the first safe slot after eret when disabled.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Holds the irq_ctrl FSM states, PCSrc codes and defaults.
package mips_pkg;

  localparam int NSRC_DEF = 4;
  localparam int HOLDOFF_DEF = 2;

  localparam logic [2:0] PCSRC_IRQ = 3'b100;
  localparam logic [2:0] PCSRC_EXC = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_TAKE    = 3'd2,
    ST_SERVICE = 3'd3,
    ST_GUARD   = 3'd4
  } irqState_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Combinational only; valid flags a non-empty input.
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (eligible[i]) idx = W'(i);
  end

  assign valid = |eligible;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending, safe-slot take.
// Define IRQ_HOLDOFF_EN to build the post-eret GUARD holdoff.
module irq_ctrl
  import mips_pkg::*;
#(
  parameter  int NSRC    = NSRC_DEF,
  parameter  int HOLDOFF = HOLDOFF_DEF,
  localparam int CW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_req,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            kernel,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic            id_branch,
  input  logic            eret,
  output logic            IRQ,
  output logic [CW-1:0]   irq_cause,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            in_isr
);

  irqState_t       state;
  irqState_t       stateNext;
  logic [NSRC-1:0] srcQ;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] takeClr;
  logic [CW-1:0]   selIdx;
  logic            anyElig;
  logic            safeSlot;
  logic            take;

  assign eligible = pending & mask;
  assign rise     = src_req & ~srcQ;
  assign safeSlot = id_valid & ~id_stall
                  & ~id_branch & ~kernel;
  assign take     = (state == ST_TAKE);
  assign IRQ      = take;
  assign in_isr   = take | (state == ST_SERVICE);

  irq_prio_enc #(
    .N(NSRC),
    .W(CW)
  ) uPrio (
    .eligible(eligible),
    .valid   (anyElig),
    .idx     (selIdx)
  );

  always_comb begin
    takeClr = '0;
    for (int i = 0; i < NSRC; i++)
      takeClr[i] = take & anyElig
                 & (selIdx == CW'(i));
  end

`ifdef IRQ_HOLDOFF_EN
  localparam int GW =
    (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [GW-1:0] GLAST =
    GW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam irqState_t AFTER_ERET = ST_GUARD;

  logic [GW-1:0] guardCnt;
  logic          guardDone;

  assign guardDone = (guardCnt == GLAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      guardCnt <= '0;
    else if (state == ST_GUARD)
      guardCnt <= guardCnt + 1'b1;
    else
      guardCnt <= '0;
  end
`else
  localparam irqState_t AFTER_ERET = ST_IDLE;
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE:
        if (anyElig) stateNext = ST_ARM;
      ST_ARM:
        if (!anyElig) stateNext = ST_IDLE;
        else if (safeSlot) stateNext = ST_TAKE;
      ST_TAKE:
        stateNext = ST_SERVICE;
      ST_SERVICE:
        if (eret) stateNext = AFTER_ERET;
`ifdef IRQ_HOLDOFF_EN
      ST_GUARD:
        if (guardDone) stateNext = ST_IDLE;
`endif
      default:
        stateNext = ST_IDLE;
    endcase
  end

  // A new edge on the bit being taken re-arms it: set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      srcQ      <= '0;
      pending   <= '0;
      mask      <= '1;
      irq_cause <= '0;
    end else begin
      state   <= stateNext;
      srcQ    <= src_req;
      pending <= (pending & ~takeClr)
               | (rise & mask);
      if (mask_wr)
        mask <= mask_wdata;
      if (take && anyElig)
        irq_cause <= selIdx;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: vector table, directed corners, random vs model.
// Honours IRQ_HOLDOFF_EN for the expected holdoff timing.
module tb_irq_ctrl;

  localparam int NSRC    = 4;
  localparam int HOLDOFF = 2;
`ifdef IRQ_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_req;
  logic       mask_wr;
  logic [3:0] mask_wdata;
  logic       kernel;
  logic       id_valid;
  logic       id_stall;
  logic       id_branch;
  logic       eret;
  logic       IRQ;
  logic [1:0] irq_cause;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       in_isr;

  int checks = 0;
  int errors = 0;
  int cycCnt = 0;

  irq_ctrl #(
    .NSRC(NSRC),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_req   (src_req),
    .mask_wr   (mask_wr),
    .mask_wdata(mask_wdata),
    .kernel    (kernel),
    .id_valid  (id_valid),
    .id_stall  (id_stall),
    .id_branch (id_branch),
    .eret      (eret),
    .IRQ       (IRQ),
    .irq_cause (irq_cause),
    .pending   (pending),
    .mask      (mask),
    .in_isr    (in_isr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] msk;
    logic [3:0] src;
    bit         expIrq;
    logic [1:0] expCause;
    logic [3:0] expPend;
  } vec_t;

  vec_t vecs[7];

  // Reference model state
  logic [3:0] mPend, mMask, mPrev;
  logic [1:0] mCause;
  bit         mTake, mIsr, mArmed;
  int         mCool;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    src_req    = '0;
    mask_wr    = 1'b0;
    mask_wdata = '0;
    kernel     = 1'b0;
    id_valid   = 1'b1;
    id_stall   = 1'b0;
    id_branch  = 1'b0;
    eret       = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic writeMask(input logic [3:0] m);
    mask_wr    = 1'b1;
    mask_wdata = m;
    tick();
    mask_wr    = 1'b0;
  endtask

  task automatic waitIrq(input int budget,
                         output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (IRQ) seen = 1'b1;
    end
  endtask

  task automatic modelReset();
    mPend  = '0;
    mMask  = '1;
    mPrev  = '0;
    mCause = '0;
    mTake  = 1'b0;
    mIsr   = 1'b0;
    mArmed = 1'b0;
    mCool  = 0;
  endtask

  // Rule-level model: one call per rising clock edge.
  task automatic modelStep();
    logic [3:0] elig;
    logic [3:0] newEdge;
    bit         safe;
    int         sel;
    elig    = mPend & mMask;
    newEdge = src_req & ~mPrev & mMask;
    safe    = id_valid && !id_stall &&
              !id_branch && !kernel;
    if (mTake) begin
      sel = -1;
      for (int i = 3; i >= 0; i--)
        if (elig[i]) sel = i;
      if (sel >= 0) begin
        mCause    = 2'(sel);
        mPend[sel] = 1'b0;
      end
      mTake = 1'b0;
      mIsr  = 1'b1;
    end else if (mIsr) begin
      if (eret) begin
        mIsr  = 1'b0;
        mCool = HOLD_EN ? HOLDOFF : 0;
      end
    end else if (mCool > 0) begin
      mCool--;
    end else if (mArmed) begin
      if (elig == 0) mArmed = 1'b0;
      else if (safe) begin
        mArmed = 1'b0;
        mTake  = 1'b1;
      end
    end else if (elig != 0) begin
      mArmed = 1'b1;
    end
    mPend = mPend | newEdge;
    if (mask_wr) mMask = mask_wdata;
    mPrev = src_req;
  endtask

  initial begin
    bit seen;
    int eretCyc;
    int gap;

    vecs[0] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 4'b0000};
    vecs[1] = '{4'b1111, 4'b1010, 1'b1, 2'd1, 4'b1000};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 2'd0, 4'b1110};
    vecs[3] = '{4'b1110, 4'b1001, 1'b1, 2'd3, 4'b0000};
    vecs[4] = '{4'b1110, 4'b0001, 1'b0, 2'd0, 4'b0000};
    vecs[5] = '{4'b0100, 4'b0110, 1'b1, 2'd2, 4'b0000};
    vecs[6] = '{4'b1111, 4'b1000, 1'b1, 2'd3, 4'b0000};

    reset = 1'b1;
    idleInputs();
    #2 reset = 1'b0;
    #1;
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_isr", 32'(in_isr), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_mask", 32'(mask), 32'hF);
    check("rst_cause", 32'(irq_cause), 32'd0);
    doReset();

    // Vector table
    foreach (vecs[k]) begin
      doReset();
      writeMask(vecs[k].msk);
      src_req = vecs[k].src;
      waitIrq(8, seen);
      check($sformatf("vec%0d_irq", k),
            32'(seen), 32'(vecs[k].expIrq));
      if (seen) begin
        tick();
        check($sformatf("vec%0d_cause", k),
              32'(irq_cause),
              32'(vecs[k].expCause));
      end
      check($sformatf("vec%0d_pend", k),
            32'(pending), 32'(vecs[k].expPend));
    end

    // Single edge on source 2, exact timing
    doReset();
    src_req = 4'b0100;
    tick();
    check("a_pend", 32'(pending), 32'b0100);
    check("a_irq_idle", 32'(IRQ), 32'd0);
    tick();
    check("a_irq_arm", 32'(IRQ), 32'd0);
    tick();
    check("a_irq_take", 32'(IRQ), 32'd1);
    check("a_isr_take", 32'(in_isr), 32'd1);
    tick();
    check("a_irq_once", 32'(IRQ), 32'd0);
    check("a_cause", 32'(irq_cause), 32'd2);
    check("a_pend_clr", 32'(pending), 32'd0);
    check("a_isr_svc", 32'(in_isr), 32'd1);
    repeat (3) tick();
    check("a_svc_hold", 32'(in_isr), 32'd1);

    // Same-cycle edges on 1 and 3, then holdoff gap
    doReset();
    src_req = 4'b1010;
    waitIrq(10, seen);
    check("b_irq1", 32'(seen), 32'd1);
    tick();
    check("b_cause1", 32'(irq_cause), 32'd1);
    check("b_pend1", 32'(pending), 32'b1000);
    eret    = 1'b1;
    eretCyc = cycCnt;
    tick();
    eret = 1'b0;
    waitIrq(20, seen);
    check("b_irq2", 32'(seen), 32'd1);
    gap = cycCnt - eretCyc;
    check("b_gap", 32'(gap),
          32'(HOLD_EN ? HOLDOFF + 3 : 3));
    tick();
    check("b_cause2", 32'(irq_cause), 32'd3);
    check("b_pend2", 32'(pending), 32'd0);

    // Kernel mode then stall hold off the take
    doReset();
    kernel  = 1'b1;
    src_req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("c_kern", 32'(IRQ), 32'd0);
    end
    kernel   = 1'b0;
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c_stall", 32'(IRQ), 32'd0);
    end
    id_stall = 1'b0;
    #1;
    check("c_pre", 32'(IRQ), 32'd0);
    tick();
    check("c_take", 32'(IRQ), 32'd1);
    tick();
    check("c_cause", 32'(irq_cause), 32'd0);

    // Masked edge is lost, unmasking later does not revive it
    doReset();
    writeMask(4'b1110);
    check("d_mask", 32'(mask), 32'b1110);
    src_req = 4'b0001;
    waitIrq(6, seen);
    check("d_noirq1", 32'(seen), 32'd0);
    check("d_pend1", 32'(pending), 32'd0);
    writeMask(4'b1111);
    waitIrq(6, seen);
    check("d_noirq2", 32'(seen), 32'd0);
    check("d_pend2", 32'(pending), 32'd0);

    // Mask write during the take cycle
    doReset();
    src_req = 4'b0011;
    waitIrq(10, seen);
    check("f_irq", 32'(seen), 32'd1);
    writeMask(4'b1110);
    check("f_cause", 32'(irq_cause), 32'd0);
    check("f_pend", 32'(pending), 32'b0010);
    check("f_mask", 32'(mask), 32'b1110);

    // Async reset in SERVICE, then high-at-release edge
    doReset();
    writeMask(4'b1010);
    src_req = 4'b1010;
    waitIrq(10, seen);
    check("e_irq", 32'(seen), 32'd1);
    tick();
    check("e_svc", 32'(in_isr), 32'd1);
    check("e_pend0", 32'(pending), 32'b1000);
    #2 reset = 1'b0;
    #1;
    check("e_isr", 32'(in_isr), 32'd0);
    check("e_irq0", 32'(IRQ), 32'd0);
    check("e_pend", 32'(pending), 32'd0);
    check("e_mask", 32'(mask), 32'hF);
    check("e_cause", 32'(irq_cause), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("e_relpend", 32'(pending), 32'b1010);
    check("e_relisr", 32'(in_isr), 32'd0);

    // Random stimulus against the model
    doReset();
    modelReset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0)
        src_req = src_req ^ 4'($urandom);
      mask_wr    = ($urandom_range(0, 15) == 0);
      mask_wdata = 4'($urandom);
      kernel     = ($urandom_range(0, 3) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_stall   = ($urandom_range(0, 3) == 0);
      id_branch  = ($urandom_range(0, 3) == 0);
      eret       = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      modelStep();
      @(negedge clk);
      check("r_irq", 32'(IRQ), 32'(mTake));
      check("r_isr", 32'(in_isr),
            32'(mTake | mIsr));
      check("r_pend", 32'(pending), 32'(mPend));
      check("r_mask", 32'(mask), 32'(mMask));
      check("r_cause", 32'(irq_cause),
            32'(mCause));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
